rmw_long_latency_mem: RTL

- Fixed-latency word store that sits directly downstream of the RMW long-latency engine.
- Services read requests tagged by the engine and returns each response exactly LATENCY cycles later. Responses are in order, with no backpressure.
- Accepts write-backs from the engine.
- On reset, self-initialises every entry to zero before accepting any traffic.

---
 rtl/rmw_long_latency_mem.sv | 115 +++++++++++
 1 files changed

// File: rtl/rmw_long_latency_mem.sv
// Fixed-latency word store behind the RMW long-latency engine: self-clearing on reset,
// in-order read responses exactly LATENCY cycles after accept, single-edge writes.
module rmw_long_latency_mem #(
    parameter int unsigned LATENCY = 20,
    parameter int unsigned DEPTH   = 256
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           rd_vld,
    input  logic [15:0]                    rd_id,
    input  logic [5:0]                     rd_tag,
    output logic                           rd_rdy,
    output logic                           rsp_vld,
    output logic [5:0]                     rsp_tag,
    output logic [31:0]                    rsp_dat,
    input  logic                           wr_vld,
    input  logic [15:0]                    wr_id,
    input  logic [31:0]                    wr_dat,
    output logic                           wr_rdy,
    output logic                           init_done,
    output logic [$clog2(LATENCY+1)-1:0]   inflight,
    output logic                           oob_err
);
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned IW    = $clog2(LATENCY + 1);
    localparam int unsigned TAG_W = 6;
    localparam int unsigned DAT_W = 32;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t                            state_q, state_d;
    logic [AW-1:0]                     ptr_q, ptr_d;
    logic                              run_q;
    logic                              init_we;
    logic [IW-1:0]                     inflight_q, inflight_d;
    logic                              oob_q, oob_d;
    logic [LATENCY-1:0]                vld_q;
    logic [LATENCY-1:0][TAG_W-1:0]     tag_q;
    logic [LATENCY-1:0][DAT_W-1:0]     dat_q;
    logic [DAT_W-1:0]                  mem_q [DEPTH];

    logic           rd_acc, wr_acc, rsp_fire;
    logic [AW-1:0]  rd_idx, wr_idx;

    assign rd_acc   = rd_vld & run_q;
    assign wr_acc   = wr_vld & run_q;
    assign rd_idx   = rd_id[AW-1:0];
    assign wr_idx   = wr_id[AW-1:0];
    assign rsp_fire = vld_q[LATENCY-1];

    // Init sweep clears one entry per cycle, then RUN until reset
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        init_we = 1'b0;
        case (state_q)
            ST_INIT: begin
                init_we = 1'b1;
                ptr_d   = ptr_q + AW'(1);
                if (ptr_q == AW'(DEPTH - 1)) state_d = ST_RUN;
            end
            ST_RUN: begin
            end
        endcase
    end

    always_comb begin
        inflight_d = inflight_q;
        if (rd_acc && !rsp_fire)      inflight_d = inflight_q + IW'(1);
        else if (!rd_acc && rsp_fire) inflight_d = inflight_q - IW'(1);
        oob_d = oob_q | (rd_acc & (|rd_id[15:AW])) | (wr_acc & (|wr_id[15:AW]));
    end

    // Delay line shifts zeros in idle slots so response fields read 0 when not valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            ptr_q      <= '0;
            run_q      <= 1'b0;
            inflight_q <= '0;
            oob_q      <= 1'b0;
            vld_q      <= '0;
            tag_q      <= '0;
            dat_q      <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            run_q      <= (state_d == ST_RUN);
            inflight_q <= inflight_d;
            oob_q      <= oob_d;
            vld_q      <= {vld_q[LATENCY-2:0], rd_acc};
            tag_q      <= {tag_q[LATENCY-2:0], rd_acc ? rd_tag : TAG_W'(0)};
            dat_q      <= {dat_q[LATENCY-2:0], rd_acc ? mem_q[rd_idx] : DAT_W'(0)};
        end
    end

    // Read samples pre-edge contents, so a same-cycle write to the same index is not seen
    always_ff @(posedge clk) begin
        if (init_we)     mem_q[ptr_q]  <= '0;
        else if (wr_acc) mem_q[wr_idx] <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (rst_n) assert (inflight_q <= IW'(LATENCY));
    end

    assign rd_rdy    = run_q;
    assign wr_rdy    = run_q;
    assign init_done = run_q;
    assign rsp_vld   = rsp_fire;
    assign rsp_tag   = tag_q[LATENCY-1];
    assign rsp_dat   = dat_q[LATENCY-1];
    assign inflight  = inflight_q;
    assign oob_err   = oob_q;
endmodule
